ctr_seq: RTL and testbench
==========================

CTR_SEQ -- requirements
Module: ctr_seq

Interface
REQ-001 Parameter size, default 8, width of the counter values being captured.
REQ-002 Parameter gw, default 16, width of the gate and timeout operands and the internal timer.
REQ-003 Parameter sw, default 4, SETTLE duration in clk cycles (sw >= 1).
REQ-004 Port clk  input  1  single system clock; all logic is on its rising edge.
REQ-005 Port rst  input  1  asynchronous reset, active low.
REQ-006 Port stt  input  1  start request, sampled while IDLE.
REQ-007 Port stp  input  1  abort request, sampled in any busy state.
REQ-008 Port gte  input  gw  gate length in clk cycles, sampled at start.
REQ-009 Port tmo  input  gw  handshake timeout in clk cycles, sampled at start.
REQ-010 Port clr  output  1  active-high clear pulse to the counter's reset input.
REQ-011 Port brq  output  1  begin trigger request.
REQ-012 Port erq  output  1  end trigger request.
REQ-013 Port bac  input  1  begin acknowledge, from a foreign clock domain.
REQ-014 Port eac  input  1  end acknowledge, from a foreign clock domain.
REQ-015 Port cnx  input  size  input-event count from the counter.
REQ-016 Port cnr  input  size  reference-clock count from the counter.
REQ-017 Port rx  output  size  captured cnx.
REQ-018 Port rr  output  size  captured cnr.
REQ-019 Port bsy  output  1  high in every state except IDLE.
REQ-020 Port dne  output  1  one-cycle completion strobe.
REQ-021 Port err  output  1  status of the last measurement: 1 = aborted or timed out.

Function
REQ-022 bac and eac SHALL each pass through a two-flop synchronizer (bas, eas) before any use; no other input is synchronized.
REQ-023 States SHALL be IDLE, CLR, ARM, GATE, STOP, SETTLE, LATCH and ABORT.
REQ-024 IDLE: bsy=0, clr=brq=erq=0; stt=1 with stp=0 -> CLR, latch gte and tmo; a gte of 0 is stored as 1.
REQ-025 CLR: clr=1 for exactly 2 cycles -> ARM; the timer is zeroed on entry to ARM.
REQ-026 ARM: brq=1; bas=1 -> GATE with the timer loaded to the gate length; timer reaching tmo first -> ABORT.
REQ-027 GATE: brq=1; the timer decrements every cycle; GATE lasts exactly the latched gate length in cycles, then -> STOP with the timer zeroed.
REQ-028 STOP: brq=erq=1; eas=1 -> SETTLE; timer reaching tmo first -> ABORT.
REQ-029 SETTLE: brq=erq=1 for exactly sw cycles -> LATCH.
REQ-030 LATCH (one cycle): rx<=cnx, rr<=cnr, err<=0, dne=1 -> IDLE.
REQ-031 ABORT (one cycle): rx and rr hold, err<=1, dne=1, brq=erq=0 -> IDLE.
REQ-032 stp=1 in CLR, ARM, GATE, STOP or SETTLE SHALL force ABORT on the next edge and has priority over every other transition.
REQ-033 stt in IDLE with stp=1 SHALL be ignored, and stt in any busy state SHALL be ignored.
REQ-034 A tmo value of 0 SHALL disable the timeout.
REQ-035 The timeout comparison SHALL be timer == tmo.
REQ-036 The timer SHALL saturate at all-ones.
REQ-037 Latency: a bac rise SHALL be followed by GATE entry on the 3rd clk edge (2 synchronizer edges plus the state edge); eac to SETTLE likewise.
REQ-038 brq, erq, clr, dne, bsy and err SHALL be registered outputs.
REQ-039 err changes only in LATCH or ABORT.

Reset
REQ-040 rst=0 SHALL asynchronously force IDLE and the following values: clr=brq=erq=bsy=dne=err=0, rx=rr=0, timer=0, synchronizers=0.
REQ-041 Reset asserted mid-measurement SHALL drop brq and erq immediately and SHALL produce no dne.
REQ-042 Leaving reset SHALL require no stt.

Verification
REQ-043 Normal run: gte=10, tmo=100, cnx=8'h2A, cnr=8'h64, bac raised 5 cycles after brq, eac raised 3 cycles after erq -> clr high exactly 2 cycles; GATE lasts 10 cycles; dne 1 cycle; rx=2A, rr=64, err=0.
REQ-044 Begin timeout: tmo=20, bac held 0 -> ABORT after 20 ARM cycles; dne=1, err=1, rx and rr unchanged, brq=0 the cycle after.
REQ-045 Abort in GATE: stp pulsed on the 4th GATE cycle -> ABORT on the next edge, err=1, no LATCH.
REQ-046 Boundary values: gte=0 -> GATE lasts 1 cycle; tmo=0 with eac delayed 1000 cycles -> no timeout and a normal LATCH.
REQ-047 Start/stop collisions: stt while bsy=1 -> ignored, with no second clr pulse; stt and stp together in IDLE -> remains IDLE.
REQ-048 Reset in STOP: rst low for one cycle -> brq=erq=0 asynchronously, IDLE state, dne never asserted.

Source files
------------

// File: rtl/ctr_seq.sv
// Measurement sequencer: clears an external counter, runs a gated begin/end
// trigger handshake with timeouts, then captures the counter values.
module ctr_seq #(
  parameter int unsigned size = 8,
  parameter int unsigned gw   = 16,
  parameter int unsigned sw   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stt,
  input  logic            stp,
  input  logic [gw-1:0]   gte,
  input  logic [gw-1:0]   tmo,
  output logic            clr,
  output logic            brq,
  output logic            erq,
  input  logic            bac,
  input  logic            eac,
  input  logic [size-1:0] cnx,
  input  logic [size-1:0] cnr,
  output logic [size-1:0] rx,
  output logic [size-1:0] rr,
  output logic            bsy,
  output logic            dne,
  output logic            err
);

  typedef enum logic [2:0] {
    IDLE, CLR, ARM, GATE, STOP, SETTLE, LATCH, ABORT
  } state_t;

  state_t          state, state_n;
  logic [gw-1:0]   timer, timer_n, t_inc;
  logic [gw-1:0]   g_len, t_lim;
  logic            ba1, bas, ea1, eas;
  logic            t_hit, busy_abortable;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ba1 <= 1'b0;
      bas <= 1'b0;
      ea1 <= 1'b0;
      eas <= 1'b0;
    end else begin
      ba1 <= bac;
      bas <= ba1;
      ea1 <= eac;
      eas <= ea1;
    end
  end

  // Timeout fires on the edge where the (saturating) timer would reach tmo.
  assign t_inc = (timer == '1) ? timer : timer + 1'b1;
  assign t_hit = (t_lim != '0) && (t_inc == t_lim);
  assign busy_abortable = (state == CLR) || (state == ARM) || (state == GATE) ||
                          (state == STOP) || (state == SETTLE);

  always_comb begin
    state_n = state;
    timer_n = timer;
    case (state)
      IDLE: begin
        if (stt && !stp) begin
          state_n = CLR;
          timer_n = '0;
        end
      end
      CLR: begin
        if (timer == gw'(1)) begin
          state_n = ARM;
          timer_n = '0;
        end else begin
          timer_n = t_inc;
        end
      end
      ARM: begin
        if (bas) begin
          state_n = GATE;
          timer_n = g_len;
        end else if (t_hit) begin
          state_n = ABORT;
          timer_n = '0;
        end else begin
          timer_n = t_inc;
        end
      end
      GATE: begin
        if (timer == gw'(1)) begin
          state_n = STOP;
          timer_n = '0;
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      STOP: begin
        if (eas) begin
          state_n = SETTLE;
          timer_n = '0;
        end else if (t_hit) begin
          state_n = ABORT;
          timer_n = '0;
        end else begin
          timer_n = t_inc;
        end
      end
      SETTLE: begin
        if (timer == gw'(sw - 1)) begin
          state_n = LATCH;
          timer_n = '0;
        end else begin
          timer_n = t_inc;
        end
      end
      LATCH, ABORT: begin
        state_n = IDLE;
        timer_n = '0;
      end
      default: begin
        state_n = IDLE;
        timer_n = '0;
      end
    endcase
    if (stp && busy_abortable) begin
      state_n = ABORT;
      timer_n = '0;
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      timer <= '0;
      g_len <= '0;
      t_lim <= '0;
      clr   <= 1'b0;
      brq   <= 1'b0;
      erq   <= 1'b0;
      bsy   <= 1'b0;
      dne   <= 1'b0;
      err   <= 1'b0;
      rx    <= '0;
      rr    <= '0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      if (state == IDLE && stt && !stp) begin
        g_len <= (gte == '0) ? gw'(1) : gte;
        t_lim <= tmo;
      end
      clr <= (state_n == CLR);
      brq <= (state_n == ARM) || (state_n == GATE) || (state_n == STOP) ||
             (state_n == SETTLE);
      erq <= (state_n == STOP) || (state_n == SETTLE);
      bsy <= (state_n != IDLE);
      dne <= (state_n == LATCH) || (state_n == ABORT);
      if (state_n == LATCH) begin
        rx  <= cnx;
        rr  <= cnr;
        err <= 1'b0;
      end else if (state_n == ABORT) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ctr_seq.sv
// Scoreboard bench for ctr_seq: expected results are queued per run and
// compared by a monitor whenever dne is presented.
module tb_ctr_seq;

  logic        clk, rst, stt, stp, bac, eac;
  logic [15:0] gte, tmo;
  logic [7:0]  cnx, cnr;
  logic        clr, brq, erq, bsy, dne, err;
  logic [7:0]  rx, rr;

  ctr_seq #(.size(8), .gw(16), .sw(4)) dut (
    .clk(clk), .rst(rst), .stt(stt), .stp(stp), .gte(gte), .tmo(tmo),
    .clr(clr), .brq(brq), .erq(erq), .bac(bac), .eac(eac),
    .cnx(cnx), .cnr(cnr), .rx(rx), .rr(rr), .bsy(bsy), .dne(dne), .err(err)
  );

  typedef struct {
    logic [7:0] rx;
    logic [7:0] rr;
    logic       err;
    int         clr_n;
    int         pre_n;   // cycles with brq && !erq, -1 = not checked
    int         gate_n;  // GATE cycles, -1 = not checked
  } exp_t;

  exp_t q[$];
  exp_t e_cur;
  int   n_cmp = 0;
  int   n_err = 0;
  int   clr_n = 0, pre_n = 0, bac_n = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Monitor: pops one expectation per dne; counters restart while idle.
  always @(negedge clk) begin
    if (rst) begin
      if (dne) begin
        if (q.size() == 0) begin
          chk("unexpected_dne", {31'd0, dne}, 32'd0);
        end else begin
          e_cur = q.pop_front();
          chk("rx", {24'd0, rx}, {24'd0, e_cur.rx});
          chk("rr", {24'd0, rr}, {24'd0, e_cur.rr});
          chk("err", {31'd0, err}, {31'd0, e_cur.err});
          chk("clr_cycles", clr_n, e_cur.clr_n);
          chk("brq_at_dne", {31'd0, brq}, 32'd0);
          chk("erq_at_dne", {31'd0, erq}, 32'd0);
          if (e_cur.pre_n >= 0) chk("arm_cycles", pre_n, e_cur.pre_n);
          // bac is seen for 3 ARM cycles (sync + state edge) before GATE
          if (e_cur.gate_n >= 0) chk("gate_cycles", bac_n - 3, e_cur.gate_n);
        end
      end
      if (!bsy) begin
        clr_n = 0; pre_n = 0; bac_n = 0;
      end else begin
        if (clr) clr_n++;
        if (brq && !erq) pre_n++;
        if (bac && brq && !erq) bac_n++;
      end
    end else begin
      clr_n = 0; pre_n = 0; bac_n = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sel(input int w);
    case (w)
      0:       return brq;
      1:       return erq;
      default: return !bsy;
    endcase
  endfunction

  task automatic wait_hi(input int w, input int max, input string nm);
    for (int i = 0; i < max; i++) begin
      if (sel(w)) return;
      tick();
    end
    chk(nm, {31'd0, sel(w)}, 32'd1);
  endtask

  task automatic push(input logic [7:0] x, input logic [7:0] r, input logic e,
                      input int p, input int g);
    exp_t t;
    t.rx = x; t.rr = r; t.err = e; t.clr_n = 2; t.pre_n = p; t.gate_n = g;
    q.push_back(t);
  endtask

  task automatic start(input logic [15:0] g, input logic [15:0] t,
                       input logic [7:0] x, input logic [7:0] r);
    gte = g; tmo = t; cnx = x; cnr = r;
    stt = 1'b1;
    tick();
    stt = 1'b0;
  endtask

  task automatic finish_run();
    wait_hi(2, 300, "idle_timeout");
    bac = 1'b0;
    eac = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

  initial begin
    rst = 1'b1; stt = 1'b0; stp = 1'b0; bac = 1'b0; eac = 1'b0;
    gte = '0; tmo = '0; cnx = '0; cnr = '0;
    #3 rst = 1'b0;
    #1;
    chk("rst_clr", {31'd0, clr}, 32'd0);
    chk("rst_brq", {31'd0, brq}, 32'd0);
    chk("rst_erq", {31'd0, erq}, 32'd0);
    chk("rst_bsy", {31'd0, bsy}, 32'd0);
    chk("rst_dne", {31'd0, dne}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_rx", {24'd0, rx}, 32'd0);
    chk("rst_rr", {24'd0, rr}, 32'd0);
    repeat (2) tick();
    rst = 1'b1;
    repeat (2) tick();

    // Normal run: gate 10, bac 5 cycles after brq, eac 3 after erq.
    push(8'h2A, 8'h64, 1'b0, -1, 10);
    start(16'd10, 16'd100, 8'h2A, 8'h64);
    wait_hi(0, 20, "brq_timeout");
    repeat (5) tick();
    bac = 1'b1;
    wait_hi(1, 50, "erq_timeout");
    repeat (3) tick();
    eac = 1'b1;
    finish_run();

    // Begin timeout after 20 ARM cycles; capture registers must hold.
    push(8'h2A, 8'h64, 1'b1, 20, -1);
    start(16'd5, 16'd20, 8'h11, 8'h22);
    finish_run();
    chk("brq_after_abort", {31'd0, brq}, 32'd0);

    // stp on the 4th GATE cycle aborts on the next edge.
    push(8'h2A, 8'h64, 1'b1, -1, 4);
    start(16'd10, 16'd100, 8'h33, 8'h44);
    wait_hi(0, 20, "brq_timeout");
    tick();
    bac = 1'b1;
    repeat (6) tick();
    stp = 1'b1;
    tick();
    stp = 1'b0;
    finish_run();

    // gte = 0 behaves as 1; stt while busy must not restart or re-clear.
    push(8'h55, 8'hAA, 1'b0, -1, 1);
    start(16'd0, 16'd100, 8'h55, 8'hAA);
    wait_hi(0, 20, "brq_timeout");
    tick();
    stt = 1'b1;
    tick();
    stt = 1'b0;
    bac = 1'b1;
    wait_hi(1, 50, "erq_timeout");
    tick();
    stt = 1'b1;
    tick();
    stt = 1'b0;
    eac = 1'b1;
    finish_run();
    chk("no_restart_bsy", {31'd0, bsy}, 32'd0);

    // tmo = 0 disables the timeout even with a 1000-cycle eac delay.
    push(8'h5A, 8'hA5, 1'b0, -1, 3);
    start(16'd3, 16'd0, 8'h5A, 8'hA5);
    wait_hi(0, 20, "brq_timeout");
    bac = 1'b1;
    wait_hi(1, 50, "erq_timeout");
    repeat (1000) tick();
    chk("tmo0_still_stop", {30'd0, erq, brq}, 32'd3);
    eac = 1'b1;
    finish_run();

    // stt together with stp in IDLE is ignored.
    stt = 1'b1;
    stp = 1'b1;
    tick();
    stt = 1'b0;
    stp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("sttstp_bsy", {31'd0, bsy}, 32'd0);
      chk("sttstp_clr", {31'd0, clr}, 32'd0);
      tick();
    end

    // Reset asserted in STOP: outputs drop asynchronously, no dne follows.
    start(16'd2, 16'd100, 8'h77, 8'h88);
    wait_hi(0, 20, "brq_timeout");
    bac = 1'b1;
    wait_hi(1, 50, "erq_timeout");
    repeat (2) tick();
    #2 rst = 1'b0;
    #1;
    chk("arst_brq", {31'd0, brq}, 32'd0);
    chk("arst_erq", {31'd0, erq}, 32'd0);
    chk("arst_bsy", {31'd0, bsy}, 32'd0);
    chk("arst_rx", {24'd0, rx}, 32'd0);
    bac = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (20) tick();
    chk("post_rst_idle", {31'd0, bsy}, 32'd0);

    chk("queue_drained", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
